mem2_wb: RTL and testbench
==========================

MEM2_WB -- requirements
Module: mem2_wb

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port flush, input, 1 bit: pipeline flush from the exception/branch unit.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): handshake from the mem1 stage; in_valid = mem1 enable AND NOT stall_by_cache.
REQ-005 SHALL have port in_rd, input, 5 bits: load destination register.
REQ-006 SHALL have port in_data, input, 32 bits: raw cache word.
REQ-007 SHALL have port in_exp, input, 7 bits: exception vector.
REQ-008 SHALL have port in_badv, input, 32 bits: bad virtual address.
REQ-009 SHALL have ports in_width (input, 2 bits) and in_sign (input, 1 bit): 0 = byte, 1 = half, 2/3 = word; in_sign = 1 means signed.
REQ-010 SHALL have port in_off, input, 2 bits: addr[1:0] of the access.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): handshake to writeback/commit.
REQ-012 SHALL have outputs out_rd (5), out_wen (1), out_data (32), out_exp (7) and out_badv (32).

Function
REQ-013 SHALL hold a 2-entry in-order FIFO; a push occurs when in_valid AND in_ready, a pop when out_valid AND out_ready.
REQ-014 SHALL drive in_ready = (count < 2) from registered state only, with no combinational path from out_ready.
REQ-015 SHALL have 1-cycle latency: an entry pushed at edge N is visible on out_* after edge N, provided the FIFO was empty.
REQ-016 SHALL update count by +1 on push only, -1 on pop only, and hold it on simultaneous push and pop at count 1.
REQ-017 SHALL allow a simultaneous push and pop at count 0 only after the entry becomes visible; there is no bypass.
REQ-018 SHALL, at count 2, deassert in_ready and hold all out_* stable while out_valid is high and out_ready is low.
REQ-019 SHALL form the aligned word at push time: shifted = in_data >> (8*in_off).
REQ-020 SHALL select the load data at push time:
  - byte: bits[7:0] of the shifted word, sign- or zero-extended per in_sign;
  - half: bits[15:0] of the shifted word, extended the same way;
  - word: the unshifted in_data.
REQ-021 SHALL store out_wen = (in_rd != 0) AND (in_exp == 0).
REQ-022 SHALL store out_data = 0 when in_exp != 0.
REQ-023 SHALL pass in_exp and in_badv through unchanged.
REQ-024 SHALL drive out_valid = (count != 0); out_* show the head entry and are 0 when empty.
REQ-025 SHALL, on flush, set count to 0 and reset both pointers at that edge, ignoring any simultaneous push or pop; in_ready = 1 on the next cycle.
REQ-026 SHALL let the read and write pointers (1 bit each) wrap from 1 to 0.

Reset
REQ-027 SHALL, while rstn is low, force count = 0 and both pointers = 0.
REQ-028 SHALL, while rstn is low, drive out_valid = 0, out_wen = 0, out_rd = 0, out_data = 0, out_exp = 0 and out_badv = 0, with in_ready = 1.
REQ-029 SHALL discard in-flight entries when reset asserts mid-operation, and SHALL NOT replay them after reset.

Configuration
REQ-030 SHALL, when CLAP_DIFFTEST_EN is defined, add inputs vaddr_diff_in, paddr_diff_in and data_diff_in and outputs vaddr_diff_out, paddr_diff_out and data_diff_out, each 32 bits.
REQ-031 SHALL carry the difftest fields in the FIFO alongside each entry, outputting them for the head entry and 0 when empty.
REQ-032 SHALL, when CLAP_DIFFTEST_EN is undefined, omit these ports and their storage, with all other behaviour identical.

Structure
REQ-033 SHALL place the width encodings (BYTE = 0, HALF = 1, WORD = 2) and the 7-bit exception vector width in the shared clap package.
REQ-034 SHALL implement alignment/extension in a combinational sub-module load_align (inputs data, off, width, sign; output word); FIFO and control stay in mem2_wb.

Verification
REQ-035 SHALL verify signed byte load: in_data = 0x12F45678, in_off = 2, width = 0, sign = 1, in_rd = 5 -> next cycle out_valid = 1, out_data = 0xFFFFFFF4, out_wen = 1, out_rd = 5.
REQ-036 SHALL verify unsigned half load: in_data = 0x8001ABCD, in_off = 2, width = 1, sign = 0 -> out_data = 0x00008001.
REQ-037 SHALL verify exception gating: in_exp = 0x04, in_badv = 0x1003 -> out_wen = 0, out_data = 0, out_exp = 0x04, out_badv = 0x1003.
REQ-038 SHALL verify backpressure: out_ready = 0 with 3 back-to-back pushes -> count = 2, in_ready = 0 and the third not accepted; then out_ready = 1 -> entries emerge in order, one per cycle.
REQ-039 SHALL verify flush: flush with count = 2 and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the flushed and concurrent entries never appear.
REQ-040 SHALL verify reset mid-operation: rstn low with count = 1 -> out_valid = 0 immediately (asynchronous); after release, no stale output.

Source files
------------

// File: rtl/clap_pkg.sv
// clap_pkg: shared load-width encodings, exception width and mem2/wb entry types
package clap_pkg;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam int EXP_W = 7;
  typedef struct packed {
    logic [4:0]       rd;
    logic             wen;
    logic [31:0]      data;
    logic [EXP_W-1:0] exp;
    logic [31:0]      badv;
  } wb_entry_t;
  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic [31:0] data;
  } diff_t;
  function automatic logic is_word(input logic [1:0] width);
    return width >= W_WORD;
  endfunction
endpackage

// File: rtl/mem2_wb_load_align.sv
// load_align: shift raw cache word by addr offset and extend byte/half loads; word loads pass unshifted
module load_align
  import clap_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  width,
  input  logic        sign,
  output logic [31:0] word
);
  logic [15:0] lo;
  assign lo = 16'(data >> {off, 3'b000});
  assign word = is_word(width) ? data
              : width == W_BYTE ? {{24{sign & lo[7]}}, lo[7:0]}
              : {{16{sign & lo[15]}}, lo};
endmodule

// File: rtl/mem2_wb.sv
// mem2_wb: 2-entry in-order mem2->writeback FIFO with load alignment; CLAP_DIFFTEST_EN adds difftest side fields
module mem2_wb
  import clap_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_data,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [31:0]      in_badv,
  input  logic [1:0]       in_width,
  input  logic             in_sign,
  input  logic [1:0]       in_off,
`ifdef CLAP_DIFFTEST_EN
  input  logic [31:0]      vaddr_diff_in,
  input  logic [31:0]      paddr_diff_in,
  input  logic [31:0]      data_diff_in,
  output logic [31:0]      vaddr_diff_out,
  output logic [31:0]      paddr_diff_out,
  output logic [31:0]      data_diff_out,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic [31:0]      out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [31:0]      out_badv
);
  logic [1:0] count;
  logic wptr, rptr, push, pop;
  logic [31:0] word;
  wb_entry_t mem [2];
  wb_entry_t new_e, head;
  assign in_ready  = count < 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  load_align u_align (.data(in_data), .off(in_off), .width(in_width), .sign(in_sign), .word(word));
  assign new_e = '{rd: in_rd, wen: (in_rd != 5'd0) && (in_exp == '0), data: (in_exp != '0) ? 32'd0 : word,
                   exp: in_exp, badv: in_badv};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) wptr <= ~wptr;
      if (pop) rptr <= ~rptr;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= new_e;
  assign head     = out_valid ? mem[rptr] : '0;
  assign out_rd   = head.rd;
  assign out_wen  = head.wen;
  assign out_data = head.data;
  assign out_exp  = head.exp;
  assign out_badv = head.badv;
`ifdef CLAP_DIFFTEST_EN
  diff_t dmem [2];
  diff_t dhead;
  always_ff @(posedge clk)
    if (push && !flush) dmem[wptr] <= '{vaddr: vaddr_diff_in, paddr: paddr_diff_in, data: data_diff_in};
  assign dhead          = out_valid ? dmem[rptr] : '0;
  assign vaddr_diff_out = dhead.vaddr;
  assign paddr_diff_out = dhead.paddr;
  assign data_diff_out  = dhead.data;
`endif
endmodule

// File: tb/tb_mem2_wb.sv
// tb_mem2_wb: table-driven scoreboard bench for mem2_wb
module tb_mem2_wb;
  logic clk = 1'b0, rstn, flush, in_valid, in_ready, in_sign, out_valid, out_ready, out_wen;
  logic [4:0] in_rd, out_rd;
  logic [31:0] in_data, in_badv, out_data, out_badv;
  logic [6:0] in_exp, out_exp;
  logic [1:0] in_width, in_off;
`ifdef CLAP_DIFFTEST_EN
  logic [31:0] vaddr_diff_out, paddr_diff_out, data_diff_out;
`endif
  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  width;
    logic        sign;
    logic [4:0]  rd;
    logic [6:0]  exp;
    logic [31:0] badv;
    logic [31:0] e_data;
    logic        e_wen;
  } vec_t;
  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [6:0]  exp;
    logic [31:0] badv;
  } exp_t;
  vec_t vecs [12];
  exp_t q[$];
  exp_t cur;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem2_wb dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .in_exp(in_exp), .in_badv(in_badv),
    .in_width(in_width), .in_sign(in_sign), .in_off(in_off),
`ifdef CLAP_DIFFTEST_EN
    .vaddr_diff_in(32'd0), .paddr_diff_in(32'd0), .data_diff_in(32'd0),
    .vaddr_diff_out(vaddr_diff_out), .paddr_diff_out(paddr_diff_out), .data_diff_out(data_diff_out),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wen(out_wen),
    .out_data(out_data), .out_exp(out_exp), .out_badv(out_badv)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input int i);
    in_valid = 1'b1;
    in_data  = vecs[i].data;
    in_off   = vecs[i].off;
    in_width = vecs[i].width;
    in_sign  = vecs[i].sign;
    in_rd    = vecs[i].rd;
    in_exp   = vecs[i].exp;
    in_badv  = vecs[i].badv;
    cur = '{rd: vecs[i].rd, wen: vecs[i].e_wen, data: vecs[i].e_data, exp: vecs[i].exp, badv: vecs[i].badv};
  endtask
  task automatic tick();
    int sz = q.size();
    chk("out_valid", out_valid, sz != 0);
    chk("in_ready", in_ready, sz < 2);
    if (sz != 0) begin
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wen", out_wen, q[0].wen);
      chk("out_data", out_data, q[0].data);
      chk("out_exp", out_exp, q[0].exp);
      chk("out_badv", out_badv, q[0].badv);
      if (out_ready) void'(q.pop_front());
    end else begin
      chk("empty_data", out_data, 0);
      chk("empty_wen", out_wen, 0);
      chk("empty_rd", out_rd, 0);
    end
    if (flush) q.delete();
    else if (in_valid && sz < 2) q.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{32'h12F45678, 2'd2, 2'd0, 1'b1, 5'd5,  7'h00, 32'h0,        32'hFFFFFFF4, 1'b1};
    vecs[1]  = '{32'h8001ABCD, 2'd2, 2'd1, 1'b0, 5'd3,  7'h00, 32'h0,        32'h00008001, 1'b1};
    vecs[2]  = '{32'hDEADBEEF, 2'd0, 2'd2, 1'b0, 5'd7,  7'h04, 32'h00001003, 32'h00000000, 1'b0};
    vecs[3]  = '{32'hCAFEBABE, 2'd1, 2'd2, 1'b1, 5'd1,  7'h00, 32'h0,        32'hCAFEBABE, 1'b1};
    vecs[4]  = '{32'h11223344, 2'd3, 2'd3, 1'b0, 5'd31, 7'h00, 32'h0,        32'h11223344, 1'b1};
    vecs[5]  = '{32'h80FF0000, 2'd3, 2'd0, 1'b0, 5'd2,  7'h00, 32'h0,        32'h00000080, 1'b1};
    vecs[6]  = '{32'h0000007F, 2'd0, 2'd0, 1'b1, 5'd0,  7'h00, 32'h0,        32'h0000007F, 1'b0};
    vecs[7]  = '{32'h1234F00D, 2'd0, 2'd1, 1'b1, 5'd4,  7'h00, 32'h0,        32'hFFFFF00D, 1'b1};
    vecs[8]  = '{32'hAA8001BB, 2'd1, 2'd1, 1'b1, 5'd6,  7'h00, 32'h0,        32'hFFFF8001, 1'b1};
    vecs[9]  = '{32'h00008000, 2'd1, 2'd0, 1'b1, 5'd9,  7'h00, 32'h0,        32'hFFFFFF80, 1'b1};
    vecs[10] = '{32'h9ABCDEF0, 2'd3, 2'd1, 1'b0, 5'd10, 7'h00, 32'h0,        32'h0000009A, 1'b1};
    vecs[11] = '{32'h00000005, 2'd0, 2'd0, 1'b1, 5'd0,  7'h40, 32'hFFFFFFFC, 32'h00000000, 1'b0};
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_off = '0; in_width = '0; in_sign = 1'b0; in_rd = '0; in_exp = '0; in_badv = '0;
    cur = '{default: '0};
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_badv", out_badv, 0);
    chk("rst_out_exp", out_exp, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(i);
      tick();
      in_valid = 1'b0;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    drive(3); tick();
    drive(4); tick();
    drive(5); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    drive(7); tick();
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_rd", out_rd, 0);
    chk("mid_rst_out_wen", out_wen, 0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    drive(8); tick();
    in_valid = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
